// File: rtl/grey_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grey_pkg
// Description : Shared types and helpers for the 3-digit Johnson-ring
//               measurement sequencer: FSM state encoding, the ten 5-bit
//               Johnson digit codes, the illegal-digit marker and the
//               code-to-BCD decode function.
// Revision    : 1.0 - initial release
// ============================================================================
package grey_pkg;

  // Measurement sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_GATE    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_VALID   = 3'd5
  } state_e;

  // Johnson (twisted-ring) codes for digits 0..9
  localparam logic [4:0] c_jc_0 = 5'b00000;
  localparam logic [4:0] c_jc_1 = 5'b00001;
  localparam logic [4:0] c_jc_2 = 5'b00011;
  localparam logic [4:0] c_jc_3 = 5'b00111;
  localparam logic [4:0] c_jc_4 = 5'b01111;
  localparam logic [4:0] c_jc_5 = 5'b11111;
  localparam logic [4:0] c_jc_6 = 5'b11110;
  localparam logic [4:0] c_jc_7 = 5'b11100;
  localparam logic [4:0] c_jc_8 = 5'b11000;
  localparam logic [4:0] c_jc_9 = 5'b10000;

  // Digit value reported for a code outside the ten legal states
  localparam logic [3:0] c_digit_illegal = 4'hF;

  // Returns {illegal, digit}
  function automatic logic [4:0] johnson_to_bcd(input logic [4:0] code);
    logic [4:0] res;
    res = {1'b1, c_digit_illegal};
    case (code)
      c_jc_0:  res = {1'b0, 4'd0};
      c_jc_1:  res = {1'b0, 4'd1};
      c_jc_2:  res = {1'b0, 4'd2};
      c_jc_3:  res = {1'b0, 4'd3};
      c_jc_4:  res = {1'b0, 4'd4};
      c_jc_5:  res = {1'b0, 4'd5};
      c_jc_6:  res = {1'b0, 4'd6};
      c_jc_7:  res = {1'b0, 4'd7};
      c_jc_8:  res = {1'b0, 4'd8};
      c_jc_9:  res = {1'b0, 4'd9};
      default: res = {1'b1, c_digit_illegal};
    endcase
    return res;
  endfunction

endpackage : grey_pkg
`default_nettype wire

// File: rtl/grey_digit_dec.sv
`default_nettype none
// ============================================================================
// Module      : grey_digit_dec
// Description : Combinational decoder for one Johnson-coded decade digit.
//               Ports:
//                 code_i    [4:0] Johnson code from one counter stage
//                 digit_o   [3:0] decoded BCD digit (4'hF when illegal)
//                 illegal_o       code is not one of the ten legal states
// Revision    : 1.0 - initial release
// ============================================================================
module grey_digit_dec
  import grey_pkg::*;
(
  input  logic [4:0] code_i,
  output logic [3:0] digit_o,
  output logic       illegal_o
);

  assign {illegal_o, digit_o} = johnson_to_bcd(code_i);

endmodule : grey_digit_dec
`default_nettype wire

// File: rtl/grey_1000_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : grey_1000_meas_ctrl
// Description : Measurement sequencer for a 3-digit ripple Johnson decade
//               counter. Clears the counter, opens the count gate for
//               GATE_CYCLES clocks, waits SETTLE_CYCLES for the ripple chain,
//               captures and decodes the digits, then offers the result on a
//               valid/ready handshake.
//               Ports:
//                 i_clk, i_rst_n       clock, async active-low reset
//                 i_start              start a measurement (IDLE only)
//                 i_continuous         re-arm after each accepted result
//                 i_100/i_010/i_001    Johnson digit codes from the counter
//                 o_cnt_rst            active-high reset to the counter
//                 o_gate               counter clock enable
//                 o_busy               sequencer not idle
//                 o_valid / i_ready    result handshake
//                 o_bcd [11:0]         {d100,d010,d001}
//                 o_err                some captured digit was illegal
// Revision    : 1.0 - initial release
// ============================================================================
module grey_1000_meas_ctrl
  import grey_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = 1000,
  parameter int unsigned CLR_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_continuous,
  input  logic [4:0]  i_100,
  input  logic [4:0]  i_010,
  input  logic [4:0]  i_001,
  output logic        o_cnt_rst,
  output logic        o_gate,
  output logic        o_busy,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [11:0] o_bcd,
  output logic        o_err
);

  localparam int unsigned c_max_gc  = (GATE_CYCLES > CLR_CYCLES) ? GATE_CYCLES : CLR_CYCLES;
  localparam int unsigned c_max_all = (c_max_gc > SETTLE_CYCLES) ? c_max_gc : SETTLE_CYCLES;
  localparam int unsigned c_cnt_w   = $clog2(c_max_all) + 1;

  state_e               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic                 cnt_rst_q, cnt_rst_d;
  logic                 gate_q, gate_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [11:0]          bcd_q, bcd_d;
  logic                 err_q, err_d;

  logic                 w_cnt_done;
  logic [14:0]          w_codes;
  logic [11:0]          w_bcd;
  logic [2:0]           w_illegal;

  // Digit decoders; index 0 is the units digit so it lands in the low nibble
  assign w_codes = {i_100, i_010, i_001};

  for (genvar g = 0; g < 3; g++) begin : g_dig
    grey_digit_dec u_dec (
      .code_i    (w_codes[g*5 +: 5]),
      .digit_o   (w_bcd[g*4 +: 4]),
      .illegal_o (w_illegal[g])
    );
  end

  // Dwell length loaded into the shared counter when a state is entered
  function automatic logic [c_cnt_w-1:0] dwell_for(input state_e s);
    logic [c_cnt_w-1:0] v;
    case (s)
      ST_CLEAR:  v = c_cnt_w'(CLR_CYCLES);
      ST_GATE:   v = c_cnt_w'(GATE_CYCLES);
      ST_SETTLE: v = c_cnt_w'(SETTLE_CYCLES);
      default:   v = c_cnt_w'(1);
    endcase
    return v;
  endfunction

  assign w_cnt_done = (cnt_q == c_cnt_w'(1));

  // Next-state and shared down-counter
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q > c_cnt_w'(1)) ? (cnt_q - c_cnt_w'(1)) : cnt_q;
    case (state_q)
      ST_IDLE:    if (i_start)    state_d = ST_CLEAR;
      ST_CLEAR:   if (w_cnt_done) state_d = ST_GATE;
      ST_GATE:    if (w_cnt_done) state_d = ST_SETTLE;
      ST_SETTLE:  if (w_cnt_done) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_VALID;
      ST_VALID: begin
        // Leave only on an actual handshake, i.e. once o_valid is visible
        if (valid_q && i_ready) begin
          state_d = i_continuous ? ST_CLEAR : ST_IDLE;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = dwell_for(state_d);
    end
  end

  // Output next-values: every output is a register fed from the current
  // state, so each output trails its state by one clock.
  always_comb begin
    cnt_rst_d = (state_q == ST_IDLE) || (state_q == ST_CLEAR);
    gate_d    = (state_q == ST_GATE);
    busy_d    = (state_q != ST_IDLE);
    valid_d   = 1'b0;
    bcd_d     = bcd_q;
    err_d     = err_q;
    if (state_q == ST_VALID) begin
      // Drop right after the accepting edge
      valid_d = !(valid_q && i_ready);
    end
    if (state_q == ST_CAPTURE) begin
      bcd_d = w_bcd;
      err_d = |w_illegal;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= c_cnt_w'(1);
      cnt_rst_q <= 1'b1;
      gate_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      bcd_q     <= 12'h000;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cnt_rst_q <= cnt_rst_d;
      gate_q    <= gate_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      bcd_q     <= bcd_d;
      err_q     <= err_d;
    end
  end

  assign o_cnt_rst = cnt_rst_q;
  assign o_gate    = gate_q;
  assign o_busy    = busy_q;
  assign o_valid   = valid_q;
  assign o_bcd     = bcd_q;
  assign o_err     = err_q;

endmodule : grey_1000_meas_ctrl
`default_nettype wire

// File: doc/grey_1000_meas_ctrl.md
Name: grey_1000_meas_ctrl

Overview:
Measurement sequencer for the 3-digit cascaded Johnson-ring decade counter (digits 100/010/001, 5-bit code each, ripple-clocked).
- Clears the counter and opens a counting gate for a fixed number of i_clk cycles.
- Closes the gate and waits for the ripple chain to settle.
- Captures and decodes the three digit codes to BCD.
- Presents the result over a valid/ready handshake.
- Sits between the counter macro and the readout/host logic, and owns the counter's reset and gate.

Parameters:
- GATE_CYCLES, 1000, number of i_clk cycles o_gate is held high per measurement (≥1)
- CLR_CYCLES, 2, number of cycles o_cnt_rst is held high in CLEAR (≥1)
- SETTLE_CYCLES, 4, number of cycles after gate close before capture, covering ripple settle (≥1)

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start one measurement; sampled only in IDLE
- i_continuous  in  1  re-arm automatically after each accepted result
- i_100  in  5  hundreds digit code from counter
- i_010  in  5  tens digit code from counter
- i_001  in  5  units digit code from counter
- o_cnt_rst  out  1  active-high reset to the counter chain
- o_gate  out  1  enable for the counter's clock source
- o_busy  out  1  high in any state except IDLE
- o_valid  out  1  result available
- i_ready  in  1  consumer accepts result
- o_bcd  out  12  {d100,d010,d001}, 4 bits per digit
- o_err  out  1  at least one captured digit code was illegal

Behaviour:
- All outputs are registered.
- Async reset: state=IDLE, o_cnt_rst=1, o_gate=0, o_busy=0, o_valid=0, o_bcd=0, o_err=0. Outputs take these values immediately, without waiting for a clock edge.
- Reset asserted mid-measurement aborts the measurement: gate closes at once, counter is held in reset, result is discarded.

FSM states: IDLE, CLEAR, GATE, SETTLE, CAPTURE, VALID.
- IDLE: o_cnt_rst=1, o_gate=0. i_start=1 → CLEAR.
- CLEAR: o_cnt_rst=1 for exactly CLR_CYCLES cycles → GATE.
- GATE: o_cnt_rst=0, o_gate=1 for exactly GATE_CYCLES cycles → SETTLE.
- SETTLE: o_gate=0 for SETTLE_CYCLES cycles → CAPTURE.
- CAPTURE: one cycle. Register decoded digits into o_bcd and OR of illegal flags into o_err → VALID.
- VALID: o_valid=1. o_bcd and o_err are held stable while i_ready=0.
  - On o_valid & i_ready: o_valid drops the next cycle.
  - If i_continuous=1 → CLEAR; else → IDLE.

Other rules:
- i_start is ignored outside IDLE; there is no queueing.
- i_continuous is sampled only at the handshake. Deasserting it mid-measurement finishes the current measurement, then returns to IDLE.
- o_cnt_rst is low in GATE, SETTLE, CAPTURE and VALID, so captured codes stay frozen.
- Inputs i_100/i_010/i_001 are sampled only in CAPTURE. The counter is frozen by then, so no synchroniser is needed.
- One shared down-counter, width clog2(max of the three parameters)+1, is loaded on every state entry. The state exits when the counter reaches 1.
- Timing from i_start sampled high at edge k:
  - o_cnt_rst held high through CLEAR
  - o_gate high on edges k+CLR_CYCLES+1 .. k+CLR_CYCLES+GATE_CYCLES
  - o_valid high from edge k+CLR_CYCLES+GATE_CYCLES+SETTLE_CYCLES+2

Johnson decode, code → digit:
- 00000→0, 00001→1, 00011→2, 00111→3, 01111→4
- 11111→5, 11110→6, 11100→7, 11000→8, 10000→9
- Any other code → digit 4'hF and an illegal flag for that digit.
- Counter wrap past 999 is not detected; GATE_CYCLES is sized by the integrator.

Decomposition:
- Package grey_pkg holds:
  - FSM state enum
  - the ten Johnson code constants
  - digit-illegal constant 4'hF
  - function johnson_to_bcd(5-bit code) returning {illegal, 4-bit digit}
- One sub-module: grey_digit_dec, a combinational 5→{1,4} decoder wrapping the function. It is instantiated three times.
- FSM and the shared down-counter stay in the top module.

Test Plan:
All scenarios use GATE_CYCLES=16, CLR_CYCLES=2, SETTLE_CYCLES=4.
1. Reset: assert i_rst_n=0 with no clock → o_cnt_rst=1, o_gate=0, o_valid=0, o_bcd=12'h000, o_err=0, o_busy=0.
2. i_start 1-cycle pulse; bench drives codes 00111/11110/10000 during SETTLE → o_cnt_rst high 2 cycles, o_gate high exactly 16 cycles, o_valid rises 5 cycles after gate falls, o_bcd=12'h369, o_err=0.
3. Backpressure: i_ready=0 for 10 cycles in VALID → o_valid=1 and o_bcd stable throughout; i_ready=1 → o_valid=0 next cycle, then IDLE and o_cnt_rst=1.
4. Illegal code: i_100=00111, i_010=01010, i_001=10000 → o_bcd=12'h3F9, o_err=1.
5. i_continuous=1 with i_ready tied high → back-to-back measurements, each gate exactly 16 cycles, separated by 2 CLEAR cycles; i_start pulses during GATE are ignored (no extra measurement).
6. i_rst_n pulled low mid-GATE (cycle 8) → o_gate=0 and o_cnt_rst=1 immediately; after release, o_valid stays 0 until a new i_start.
